// File: rtl/vga_tp_pkg.sv
// Shared mode encoding and bar colour helper
// for the VGA test-pattern generator.
package vga_tp_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_VBARS   = 2'd0,
        MODE_HBARS   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_e;

    // Bar i shows colour (i+1) mod 2^rgb_w; callers truncate to their width.
    function automatic logic [15:0] bar_colour(
        input logic [4:0] idx,
        input int         rgb_w
    );
        logic [15:0] c;
        c = 16'(idx) + 16'd1;
        return c & 16'((32'd1 << rgb_w) - 32'd1);
    endfunction

endpackage

// File: rtl/tp_bar_counter.sv
// Incremental bar-index tracker for a raster coordinate;
// re-zeros whenever the coordinate is 0, saturates at NUM-1.
module tp_bar_counter #(
    parameter  int LEN = 80,
    parameter  int NUM = 8,
    parameter  int CW  = 10,
    localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1,
    localparam int OW  = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] coord_i,
    input  logic          step_i,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] idx_q, idx_d, base_idx;
    logic [OW-1:0] off_q, off_d, base_off;
    logic          at_zero;

    // State describes the coordinate expected next; coordinate 0 overrides it.
    assign at_zero  = (coord_i == '0);
    assign base_idx = at_zero ? '0 : idx_q;
    assign base_off = at_zero ? '0 : off_q;
    assign idx_o    = base_idx;

    always_comb begin
        idx_d = idx_q;
        off_d = off_q;
        if (step_i) begin
            idx_d = base_idx;
            off_d = base_off;
            if (base_idx != IW'(NUM - 1)) begin
                if (base_off == OW'(LEN - 1)) begin
                    idx_d = base_idx + IW'(1);
                    off_d = '0;
                end else begin
                    off_d = base_off + OW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            off_q <= '0;
        end else begin
            idx_q <= idx_d;
            off_q <= off_d;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: bars, checkerboard, scrolling bars
// with frame-synchronous mode switching and optional auto-cycling.
module vga_pattern_gen
    import vga_tp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_BARS    = 8,
    parameter int RGB_W       = 3,
    parameter int CHECK_LOG2  = 5,
    parameter int AUTO_FRAMES = 120,
    parameter int SCROLL_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic             video_on,
    input  logic [9:0]       pix_x,
    input  logic [9:0]       pix_y,
    input  logic             mode_next,
    input  logic             auto_en,
    output logic [RGB_W-1:0] rgb,
    output logic [1:0]       mode
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BAR_H = V_ACTIVE / NUM_BARS;
    localparam int BW    = $clog2(NUM_BARS);
    localparam int FW    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam int DW    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [BW-1:0]    bx, by;
    logic             frame_tick, advance;
    mode_e            mode_q, mode_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    soff_q, soff_d;
    logic             pend_q, pend_d;
    logic [RGB_W-1:0] rgb_q, rgb_d, pat;
    logic [BW:0]      ssum;

    tp_bar_counter #(.LEN(BAR_W), .NUM(NUM_BARS), .CW(10)) u_xcnt (
        .clk    (clk),
        .reset  (reset),
        .coord_i(pix_x),
        .step_i (p_tick),
        .idx_o  (bx)
    );

    tp_bar_counter #(.LEN(BAR_H), .NUM(NUM_BARS), .CW(10)) u_ycnt (
        .clk    (clk),
        .reset  (reset),
        .coord_i(pix_y),
        .step_i (p_tick && (pix_x == 10'(H_ACTIVE - 1))),
        .idx_o  (by)
    );

    assign frame_tick = p_tick && (pix_x == '0) && (pix_y == '0);
    assign advance    = pend_q | mode_next
                      | (auto_en && (fcnt_q == FW'(AUTO_FRAMES - 1)));

    always_comb begin
        mode_d = mode_q;
        fcnt_d = fcnt_q;
        div_d  = div_q;
        soff_d = soff_q;
        pend_d = pend_q | mode_next;
        if (frame_tick) begin
            if (advance) begin
                mode_d = mode_e'(mode_q + MODE_W'(1));
                fcnt_d = '0;
                pend_d = 1'b0;
                soff_d = '0;
                div_d  = '0;
            end else begin
                if (fcnt_q != FW'(AUTO_FRAMES - 1))
                    fcnt_d = fcnt_q + FW'(1);
                if (mode_q == MODE_SCROLL) begin
                    if (div_q == DW'(SCROLL_DIV - 1)) begin
                        div_d  = '0;
                        soff_d = (soff_q == BW'(NUM_BARS - 1))
                               ? '0 : soff_q + BW'(1);
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            end
        end
    end

    // Render with next-state mode/offset so the frame_tick pixel matches its frame.
    always_comb begin
        ssum = {1'b0, bx} + {1'b0, soff_d};
        if (ssum >= (BW + 1)'(NUM_BARS))
            ssum = ssum - (BW + 1)'(NUM_BARS);
        pat = '0;
        unique case (mode_d)
            MODE_VBARS:   pat = RGB_W'(bar_colour(5'(bx), RGB_W));
            MODE_HBARS:   pat = RGB_W'(bar_colour(5'(by), RGB_W));
            MODE_CHECKER: pat = {RGB_W{pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2]}};
            MODE_SCROLL:  pat = RGB_W'(bar_colour(5'(ssum[BW-1:0]), RGB_W));
        endcase
        rgb_d = rgb_q;
        if (p_tick)
            rgb_d = video_on ? pat : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_VBARS;
            fcnt_q <= '0;
            div_q  <= '0;
            soff_q <= '0;
            pend_q <= 1'b0;
            rgb_q  <= '0;
        end else begin
            mode_q <= mode_d;
            fcnt_q <= fcnt_d;
            div_q  <= div_d;
            soff_q <= soff_d;
            pend_q <= pend_d;
            rgb_q  <= rgb_d;
        end
    end

    assign rgb  = rgb_q;
    assign mode = mode_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised, multi-mode VGA test-pattern generator.
- Sits between the vga_sync timing block (pix_x, pix_y, video_on, p_tick) and the RGB output pins.
- Generalises the fixed 8-bar colour strip to:
  - N bars of configurable colour depth.
  - Four selectable patterns: vertical bars, horizontal bars, checkerboard, scrolling bars.
  - Frame-synchronous mode switching, with optional auto-cycling.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- NUM_BARS, 8, bars per pattern (2..16).
- RGB_W, 3, output colour width.
- CHECK_LOG2, 5, checker square side = 2^CHECK_LOG2 pixels.
- AUTO_FRAMES, 120, frames per mode when auto-cycling is enabled (must be ≥1).
- SCROLL_DIV, 4, frames per one-bar scroll step.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- p_tick  input  1  pixel-enable strobe from vga_sync.
- video_on  input  1  high inside the visible area.
- pix_x  input  10  current pixel column.
- pix_y  input  10  current pixel row.
- mode_next  input  1  single-cycle request to advance the mode.
- auto_en  input  1  enables auto-cycling every AUTO_FRAMES frames.
- rgb  output  RGB_W  registered pixel colour.
- mode  output  2  current pattern mode.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset values: rgb=0, mode=0 (VBARS). Frame counter, scroll offset, mode_next pending flag and bar counters all 0.
- Mode encoding: 0 VBARS, 1 HBARS, 2 CHECKER, 3 SCROLL.
- Constants:
  - BAR_W = H_ACTIVE/NUM_BARS.
  - BAR_H = V_ACTIVE/NUM_BARS.
  - Remainder pixels belong to the last bar.
- Bar colour: bar i has colour (i+1) mod 2^RGB_W.
- Bar index:
  - bx = min(pix_x/BAR_W, NUM_BARS-1); by likewise for pix_y with BAR_H.
  - Both must come from incremental counters (tp_bar_counter). No divider, no per-bar comparator array.
- Patterns:
  - VBARS: colour(bx).
  - HBARS: colour(by).
  - CHECKER: all-ones if bit CHECK_LOG2 of pix_x XOR bit CHECK_LOG2 of pix_y is 1, else 0.
  - SCROLL: colour((bx + scroll_off) mod NUM_BARS).
- Output timing:
  - rgb updates only on a cycle with p_tick=1: rgb <= video_on ? pattern(pix_x, pix_y) : 0.
  - Latency is exactly one p_tick. rgb holds its value between ticks.
- frame_tick = p_tick & (pix_x==0) & (pix_y==0).
- mode_next:
  - Sets the pending flag on any cycle.
  - Multiple pulses within one frame collapse to one advance.
  - A pulse on the frame_tick cycle itself is applied at that frame_tick.
- At each frame_tick:
  - advance = pending | (auto_en & frame_cnt==AUTO_FRAMES-1).
  - If advance: mode <= mode+1 (wraps 3→0), frame_cnt <= 0, pending <= 0, scroll_off <= 0, scroll_div_cnt <= 0. Simultaneous manual and auto requests advance by one only.
  - Else: frame_cnt increments, saturating at AUTO_FRAMES-1 when auto_en=0.
  - In SCROLL with no advance: scroll_div_cnt increments. At SCROLL_DIV-1 it wraps to 0 and scroll_off <= (scroll_off+1) mod NUM_BARS.
- The mode used for rendering changes only at frame_tick. No mid-frame tearing.
- Reset asserted mid-frame: all state clears immediately. After release, output is valid from the next p_tick. The mode stays VBARS until a request arrives.
- pix_x/pix_y beyond active range are masked by video_on and do not corrupt the bar counters: the counters re-zero at pix_x==0 and pix_y==0 respectively.

Decomposition:
- Package vga_tp_pkg holds:
  - Mode localparams (MODE_VBARS..MODE_SCROLL).
  - Mode width (2).
  - bar_colour function (index, RGB_W) returning (i+1) mod 2^RGB_W.
- Sub-module tp_bar_counter, parameters LEN (bar size) and NUM (bar count):
  - Inputs: coordinate, step strobe.
  - Output: bar index, saturating at NUM-1.
  - Instantiated twice:
    - x: stepped on p_tick.
    - y: stepped on p_tick when pix_x==H_ACTIVE-1.

Test Plan:
- Defaults, mode 0, full frame scan:
  - pix_x=0 → rgb=001; pix_x=79 → 001; pix_x=80 → 010; pix_x=639 → 000.
  - rgb appears one p_tick after the coordinate is applied.
- video_on=0 at pix_x=700 → rgb=000; no p_tick for 5 cycles → rgb holds its last value.
- mode_next pulse mid-frame → mode stays 0 until next frame_tick, then mode=1. In HBARS: pix_y=59 → 001; pix_y=60 → 010.
- Two mode_next pulses in one frame plus auto_en with frame_cnt at 119 → mode advances by exactly one; 3→0 wrap checked.
- Mode 2, CHECK_LOG2=5: (x=0,y=0) → 000; (32,0) → 111; (32,32) → 000.
- Mode 3, SCROLL_DIV=4: after 4 frame_ticks pix_x=0 → 010. Reset asserted mid-line → rgb=0 and mode=0 in the same cycle; scroll_off=0 after release.
